// File: rtl/mps_relay_output_driver.sv
// MPS power-stage relay driver: sequencer-driven relay requests with break-before-make
// dead time, debounced aux-contact feedback, feedback supervision and a latched trip.
module mps_relay_output_driver #(
  parameter int DEAD_CYC = 1_000_000,
  parameter int DEB_CYC  = 10_000,
  parameter int FB_TMO   = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_on_state,
  input  logic [3:0]  i_off_state,
  input  logic        i_intl,
  input  logic [15:0] i_ext_di,
  output logic        o_discha_do,
  output logic        o_slow_do,
  output logic        o_main_do,
  output logic [2:0]  o_fb_di,
  output logic [2:0]  o_fb_fault,
  output logic        o_trip
);

  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam int BW = $clog2(DEB_CYC + 1);
  localparam int TW = $clog2(FB_TMO + 1);

  localparam logic [3:0] ON_CLR          = 4'd1;
  localparam logic [3:0] ON_DISCHA_CHK   = 4'd4;
  localparam logic [3:0] ON_SLOW_ON_CHK  = 4'd6;
  localparam logic [3:0] ON_MAIN_CHK     = 4'd10;
  localparam logic [3:0] ON_SLOW_OFF_CHK = 4'd12;
  localparam logic [3:0] ON_FAIL         = 4'd15;
  localparam logic [3:0] OFF_MAIN_OFF    = 4'd1;
  localparam logic [3:0] OFF_DISCHA_ON   = 4'd2;

  localparam logic [2:0] FB_RESET  = 3'b100;
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_TRIP   = 1'b1;

  logic [0:0]    state, state_next;
  logic          discha_req, slow_req, main_req;
  logic          discha_req_next, slow_req_next, main_req_next;
  logic          discha_do_next, slow_do_next, main_do_next;
  logic [DW-1:0] dcnt, pcnt, dcnt_next, pcnt_next;
  logic [2:0]    sync1, sync2, relay_do;
  logic          trip_clear;
  logic          unused_di;

  assign unused_di  = ^{i_ext_di[15:4], i_ext_di[0]};
  assign o_trip     = (state == ST_TRIP);
  assign trip_clear = o_trip && (i_on_state == ON_CLR) && !i_intl;
  assign relay_do   = {o_discha_do, o_slow_do, o_main_do};

  always_comb begin
    state_next = state;
    case (state)
      ST_NORMAL: if (i_intl || (|o_fb_fault)) state_next = ST_TRIP;
      default:   if ((i_on_state == ON_CLR) && !i_intl) state_next = ST_NORMAL;
    endcase
  end

  // Clear beats set; an active trip overrides everything with the safe request set.
  always_comb begin
    discha_req_next = discha_req;
    slow_req_next   = slow_req;
    main_req_next   = main_req;
    if (i_on_state == ON_FAIL || i_off_state == OFF_DISCHA_ON) discha_req_next = 1'b1;
    if (i_on_state == ON_DISCHA_CHK) discha_req_next = 1'b0;
    if (i_on_state == ON_SLOW_ON_CHK) slow_req_next = 1'b1;
    if (i_on_state == ON_SLOW_OFF_CHK || i_on_state == ON_FAIL || i_off_state == OFF_MAIN_OFF)
      slow_req_next = 1'b0;
    if (i_on_state == ON_MAIN_CHK) main_req_next = 1'b1;
    if (i_on_state == ON_FAIL || i_off_state == OFF_MAIN_OFF) main_req_next = 1'b0;
    if (o_trip) begin
      discha_req_next = 1'b1;
      slow_req_next   = 1'b0;
      main_req_next   = 1'b0;
    end
  end

  // Dead-time counters track the cycle being entered, so a count of DEAD_CYC means
  // the conflicting side has been open for DEAD_CYC full cycles.
  always_comb begin
    discha_do_next = discha_req && ((pcnt == DW'(DEAD_CYC)) || o_discha_do);
    slow_do_next   = slow_req && !discha_req && (dcnt == DW'(DEAD_CYC));
    main_do_next   = main_req && !discha_req && (dcnt == DW'(DEAD_CYC));
    if (discha_do_next)                dcnt_next = '0;
    else if (dcnt == DW'(DEAD_CYC))    dcnt_next = dcnt;
    else                               dcnt_next = dcnt + DW'(1);
    if (slow_do_next || main_do_next)  pcnt_next = '0;
    else if (pcnt == DW'(DEAD_CYC))    pcnt_next = pcnt;
    else                               pcnt_next = pcnt + DW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_NORMAL;
      discha_req  <= 1'b1;
      slow_req    <= 1'b0;
      main_req    <= 1'b0;
      o_discha_do <= 1'b1;
      o_slow_do   <= 1'b0;
      o_main_do   <= 1'b0;
      dcnt        <= '0;
      pcnt        <= DW'(DEAD_CYC);
      sync1       <= FB_RESET;
      sync2       <= FB_RESET;
    end else begin
      state       <= state_next;
      discha_req  <= discha_req_next;
      slow_req    <= slow_req_next;
      main_req    <= main_req_next;
      o_discha_do <= discha_do_next;
      o_slow_do   <= slow_do_next;
      o_main_do   <= main_do_next;
      dcnt        <= dcnt_next;
      pcnt        <= pcnt_next;
      sync1       <= i_ext_di[3:1];
      sync2       <= sync1;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_fb
    logic [BW-1:0] deb_cnt;
    logic [TW-1:0] mm_cnt;
    logic          fb_bit;
    logic          fault_bit;

    // A pending change at the synchroniser output restarts the stability window.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        deb_cnt <= '0;
        fb_bit  <= FB_RESET[gi];
      end else begin
        if (sync1[gi] != sync2[gi])         deb_cnt <= '0;
        else if (deb_cnt != BW'(DEB_CYC))   deb_cnt <= deb_cnt + BW'(1);
        if (deb_cnt == BW'(DEB_CYC))        fb_bit  <= sync2[gi];
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        mm_cnt    <= '0;
        fault_bit <= 1'b0;
      end else if (trip_clear) begin
        mm_cnt    <= '0;
        fault_bit <= 1'b0;
      end else if (fb_bit != relay_do[gi]) begin
        if (mm_cnt != TW'(FB_TMO))       mm_cnt    <= mm_cnt + TW'(1);
        if (mm_cnt == TW'(FB_TMO - 1))   fault_bit <= 1'b1;
      end else begin
        mm_cnt <= '0;
      end
    end

    assign o_fb_di[gi]    = fb_bit;
    assign o_fb_fault[gi] = fault_bit;
  end

endmodule
